// File: rtl/prescaler_mc_pkg.sv
// Shared encodings and parameter limits for the multi-channel event prescaler.
// Qualification modes are the values carried on cfg_mode_i.
package prescaler_mc_pkg;

  localparam logic PRESC_MODE_LEVEL = 1'b0;
  localparam logic PRESC_MODE_EDGE  = 1'b1;

  localparam int N_CH_MIN  = 1;
  localparam int N_CH_MAX  = 8;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 32;

endpackage

// File: rtl/prescaler_mc_ch.sv
// One prescaler channel: divides qualified events by presc+1, shadows mid-run updates.
// Latency: terminal event in cycle n -> event_o in cycle n+1; no backpressure.
module prescaler_mc_ch
  import prescaler_mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             active_i,
  input  logic             update_i,
  input  logic             srst_i,
  input  logic [CNT_W-1:0] presc_i,
  input  logic             mode_i,
  input  logic             event_i,
  output logic             event_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             upd_pend_o
);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             evt_q, evt_d;
  logic             prev_q, prev_d;
  logic             act_q, act_d;
  logic             qev, hit, term;

  always_comb begin
    prev_d   = event_i;
    act_d    = active_i;
    cnt_d    = cnt_q;
    evt_d    = 1'b0;
    presc_d  = presc_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;

    qev  = (mode_i == PRESC_MODE_EDGE) ? (event_i & ~prev_q) : event_i;
    hit  = qev & ((presc_q == '0) | (cnt_q == presc_q));
    term = active_i & ~srst_i & hit;

    if (srst_i || !active_i) begin
      cnt_d = '0;
    end else if (hit) begin
      evt_d = 1'b1;
      cnt_d = '0;
    end else if (qev) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // A pending value lands at a terminal event or on the first cycle after reactivation.
    if (pend_q && (term || (active_i && !act_q))) begin
      presc_d = shadow_q;
      pend_d  = 1'b0;
    end

    if (update_i) begin
      if (!active_i || srst_i || term) begin
        presc_d = presc_i;
        pend_d  = 1'b0;
      end else begin
        shadow_d = presc_i;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      presc_q  <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      evt_q    <= 1'b0;
      prev_q   <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      evt_q    <= evt_d;
      prev_q   <= prev_d;
      act_q    <= act_d;
    end
  end

  assign event_o    = evt_q;
  assign cnt_o      = cnt_q;
  assign upd_pend_o = pend_q;

endmodule

// File: rtl/prescaler_mc.sv
// N_CH independent event prescalers between input-select and timer counters.
// Latency: one cycle from terminal event to event_o; no backpressure.
module prescaler_mc
  import prescaler_mc_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [N_CH-1:0]       ctrl_active_i,
  input  logic [N_CH-1:0]       ctrl_update_i,
  input  logic [N_CH-1:0]       ctrl_rst_i,
  input  logic [N_CH*CNT_W-1:0] cfg_presc_i,
  input  logic [N_CH-1:0]       cfg_mode_i,
  input  logic [N_CH-1:0]       event_i,
  output logic [N_CH-1:0]       event_o,
  output logic [N_CH*CNT_W-1:0] cnt_o,
  output logic [N_CH-1:0]       upd_pend_o
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    prescaler_mc_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .active_i   (ctrl_active_i[k]),
      .update_i   (ctrl_update_i[k]),
      .srst_i     (ctrl_rst_i[k]),
      .presc_i    (cfg_presc_i[k*CNT_W +: CNT_W]),
      .mode_i     (cfg_mode_i[k]),
      .event_i    (event_i[k]),
      .event_o    (event_o[k]),
      .cnt_o      (cnt_o[k*CNT_W +: CNT_W]),
      .upd_pend_o (upd_pend_o[k])
    );
  end

endmodule
